// File: rtl/dd_ack_gen.sv
// Receiver-side ACK generator: tracks received packets in a sliding bitmap,
// advances the cumulative ACK over contiguous seqs and emits one ACK per packet.
module dd_ack_gen #(
    parameter int SEQ_W     = 32,
    parameter int WIN_SIZE  = 128,
    parameter int WIN_IND_W = 7,
    parameter int TX_CNT_W  = 2,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                data_val_in,
    output logic                data_rdy_out,
    input  logic [SEQ_W-1:0]    data_seq_in,
    input  logic [TX_CNT_W-1:0] data_tx_id_in,
    output logic                ack_val_out,
    input  logic                ack_rdy_in,
    output logic [SEQ_W-1:0]    ack_cum_out,
    output logic [SEQ_W-1:0]    ack_sack_out,
    output logic [TX_CNT_W-1:0] ack_tx_id_out,
    output logic [CNT_W-1:0]    dup_cnt_out,
    output logic [CNT_W-1:0]    drop_cnt_out
);

    typedef enum logic [1:0] {IDLE, UPDATE, ADVANCE, SEND} state_t;

    state_t                state, state_nxt;
    logic                  armed;
    logic [WIN_SIZE-1:0]   bitmap;
    logic [SEQ_W-1:0]      wnd_start;
    logic [WIN_IND_W-1:0]  wnd_start_ind;
    logic [SEQ_W-1:0]      seq_q;
    logic [TX_CNT_W-1:0]   tx_id_q;
    logic [CNT_W-1:0]      dup_cnt, drop_cnt;
    logic [SEQ_W-1:0]      off;
    logic [WIN_IND_W-1:0]  idx;
    logic                  accept, is_drop, is_dup;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign accept  = data_val_in && data_rdy_out;
    assign off     = seq_q - wnd_start;
    assign idx     = wnd_start_ind + off[WIN_IND_W-1:0];
    assign is_drop = (seq_q >= wnd_start) && (off >= SEQ_W'(WIN_SIZE));
    // Bitmap lookup only means anything for in-window offsets; far seqs alias.
    assign is_dup  = (seq_q < wnd_start) || (!is_drop && bitmap[idx]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = UPDATE;
            UPDATE:  state_nxt = (is_dup || is_drop) ? SEND : ADVANCE;
            ADVANCE: if (!bitmap[wnd_start_ind]) state_nxt = SEND;
            SEND:    if (ack_rdy_in) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        data_rdy_out  = armed && (state == IDLE);
        ack_val_out   = (state == SEND);
        ack_cum_out   = '0;
        ack_sack_out  = '0;
        ack_tx_id_out = '0;
        if (state == SEND) begin
            ack_cum_out   = wnd_start;
            ack_sack_out  = seq_q;
            ack_tx_id_out = tx_id_q;
        end
    end

    assign dup_cnt_out  = dup_cnt;
    assign drop_cnt_out = drop_cnt;

    // armed holds data_rdy_out low for the first cycle after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed         <= 1'b0;
            bitmap        <= '0;
            wnd_start     <= '0;
            wnd_start_ind <= '0;
            dup_cnt       <= '0;
            drop_cnt      <= '0;
        end else begin
            armed <= 1'b1;
            if (state == UPDATE) begin
                if (is_dup)       dup_cnt     <= sat_inc(dup_cnt);
                else if (is_drop) drop_cnt    <= sat_inc(drop_cnt);
                else              bitmap[idx] <= 1'b1;
            end
            if (state == ADVANCE && bitmap[wnd_start_ind]) begin
                bitmap[wnd_start_ind] <= 1'b0;
                wnd_start             <= wnd_start + SEQ_W'(1);
                wnd_start_ind         <= wnd_start_ind + WIN_IND_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            seq_q   <= data_seq_in;
            tx_id_q <= data_tx_id_in;
        end
    end

endmodule
